// File: rtl/frame_pkg.sv
// Shared types and default parameters for the frame compositor and its layer mux.
package frame_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } game_state_t;

  localparam int unsigned N_LAYERS_DEFAULT     = 8;
  localparam int unsigned RGB_W_DEFAULT        = 12;
  localparam int unsigned HEALTH_W_DEFAULT     = 4;
  localparam int unsigned BLINK_FRAMES_DEFAULT = 60;
  localparam int unsigned BLINK_SHIFT_DEFAULT  = 2;

endpackage

// File: rtl/layer_priority_sel.sv
// Combinational sprite-layer mux: the lowest set index wins, background when no layer claims
// the pixel.
module layer_priority_sel #(
  parameter int unsigned N_LAYERS = 8,
  parameter int unsigned RGB_W    = 12
) (
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [RGB_W-1:0]          bg_rgb,
  output logic [RGB_W-1:0]          sel_rgb
);

  // Walk from the lowest priority upward so the last hit is the highest-priority layer.
  always_comb begin
    sel_rgb = bg_rgb;
    for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
      if (layer_en[i]) begin
        sel_rgb = layer_rgb[i*RGB_W +: RGB_W];
      end
    end
  end

endmodule

// File: rtl/frame_compositor.sv
// Per-pixel compositor with START/PLAY/OVER sequencing, post-hit player blink and a fixed
// two-stage output pipeline.
module frame_compositor
  import frame_pkg::*;
#(
  parameter int unsigned N_LAYERS     = N_LAYERS_DEFAULT,
  parameter int unsigned RGB_W        = RGB_W_DEFAULT,
  parameter int unsigned HEALTH_W     = HEALTH_W_DEFAULT,
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEFAULT,
  parameter int unsigned BLINK_SHIFT  = BLINK_SHIFT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [RGB_W-1:0]          bg_rgb,
  input  logic [RGB_W-1:0]          start_rgb,
  input  logic [RGB_W-1:0]          over_rgb,
  input  logic                      enter,
  input  logic                      hit,
  input  logic [HEALTH_W-1:0]       health,
  output logic [RGB_W-1:0]          pix_rgb,
  output logic [1:0]                game_state,
  output logic                      play_en,
  output logic                      end_en
);

  localparam int unsigned BLINK_W = (BLINK_FRAMES == 0) ? 1 : $clog2(BLINK_FRAMES + 1);

  game_state_t          state_q, state_d;
  game_state_t          pend_q, pend_d;
  logic                 enter_q, enter_rise;
  logic                 play_en_q, end_en_q;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 player_hide;
  logic [N_LAYERS-1:0]  eff_en;
  logic [RGB_W-1:0]     sel_rgb, sel_q;
  logic [RGB_W-1:0]     pix_d, pix_q;

  // Requests accumulate in pend_q; the visible mode only moves on a frame boundary.
  always_comb begin
    enter_rise = enter & ~enter_q;
    pend_d     = pend_q;
    case (state_q)
      ST_START: if (enter_rise) pend_d = ST_PLAY;
      ST_PLAY:  if (health == '0) pend_d = ST_OVER;
      ST_OVER:  if (enter_rise) pend_d = ST_START;
      default:  pend_d = ST_START;
    endcase
    state_d = frame_start ? pend_d : state_q;
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    if (state_d != state_q) begin
      blink_cnt_d = '0;
    end else if (hit && (state_q == ST_PLAY)) begin
      blink_cnt_d = BLINK_W'(BLINK_FRAMES);
    end else if (frame_start && (blink_cnt_q != '0)) begin
      blink_cnt_d = blink_cnt_q - BLINK_W'(1);
    end
  end

  // A shift beyond the counter width masks to zero, so the player is then never hidden.
  always_comb begin
    player_hide = (blink_cnt_q != '0) &&
                  ((blink_cnt_q & (BLINK_W'(1) << BLINK_SHIFT)) != '0);
    eff_en      = layer_en;
    eff_en[0]   = layer_en[0] & ~player_hide;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_START;
      pend_q      <= ST_START;
      enter_q     <= 1'b0;
      blink_cnt_q <= '0;
      play_en_q   <= 1'b0;
      end_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      enter_q     <= enter;
      blink_cnt_q <= blink_cnt_d;
      play_en_q   <= (state_d == ST_PLAY);
      end_en_q    <= (state_d == ST_OVER);
    end
  end

  layer_priority_sel #(
    .N_LAYERS (N_LAYERS),
    .RGB_W    (RGB_W)
  ) u_layer_priority_sel (
    .layer_en  (eff_en),
    .layer_rgb (layer_rgb),
    .bg_rgb    (bg_rgb),
    .sel_rgb   (sel_rgb)
  );

  // Screen override uses the mode current at stage 2.
  always_comb begin
    case (state_q)
      ST_START: pix_d = start_rgb;
      ST_OVER:  pix_d = over_rgb;
      default:  pix_d = sel_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= '0;
      pix_q <= '0;
    end else begin
      sel_q <= sel_rgb;
      pix_q <= pix_d;
    end
  end

  assign pix_rgb    = pix_q;
  assign game_state = state_q;
  assign play_en    = play_en_q;
  assign end_en     = end_en_q;

endmodule
